port_stat_regfile: RTL

- Responder end of the per-port statistics handshake (port_addr/port_din/port_req/port_ack) driven by each MAC port's status reporter.
- Arbitrates among NUM_PORTS requesters and accumulates each 16-bit report into a 32-bit counter selected by port_addr.
- Exposes a registered management read port with optional clear-on-read.
- Sits in the switch core next to the per-port MAC tops, in the single core clock domain.

---
 rtl/port_stat_regfile.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/port_stat_regfile.sv
// port_stat_regfile: round-robin arbitrated per-port statistics counters with a registered management read port.
// Define PORT_STAT_SAT_EN to clamp counter accumulation at 32'hFFFFFFFF instead of wrapping modulo 2^32.
module port_stat_regfile #(
    parameter int unsigned NUM_PORTS = 4,
    parameter logic [6:0]  ADDR_BASE = 7'h10,
    parameter int unsigned NUM_REGS  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7*NUM_PORTS-1:0]  port_addr,
    input  logic [16*NUM_PORTS-1:0] port_din,
    input  logic [NUM_PORTS-1:0]    port_req,
    output logic [NUM_PORTS-1:0]    port_ack,
    input  logic                    rd_en,
    input  logic [6:0]              rd_addr,
    input  logic                    rd_clr,
    output logic [31:0]             rd_data,
    output logic                    rd_valid,
    output logic [15:0]             addr_err_cnt
);
    localparam int unsigned PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned RW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned ADDR_LIMIT = 32'(ADDR_BASE) + NUM_REGS;

    typedef enum logic [1:0] {IDLE, UPDATE, ACK} state_t;
    state_t state, state_next;

    logic [NUM_PORTS-1:0]       mask;
    logic [NUM_PORTS-1:0]       cand;
    logic [PW-1:0]              rr_ptr;
    logic [PW-1:0]              g;
    logic [PW-1:0]              pick;
    logic                       found;
    logic [6:0]                 sel_addr;
    logic [15:0]                sel_din;
    logic [6:0]                 upd_addr;
    logic [15:0]                upd_din;
    int unsigned                rr_idx;
    logic                       grant;
    logic                       do_update;
    logic [NUM_REGS-1:0][31:0]  cnt;

    logic                       upd_mapped;
    logic                       rd_mapped;
    logic [RW-1:0]              upd_idx;
    logic [RW-1:0]              rd_idx;
    logic                       clr_hit;
    logic                       upd_hit;
    logic [31:0]                upd_base;
    logic [31:0]                upd_val;
`ifdef PORT_STAT_SAT_EN
    logic [32:0]                upd_sum;
`endif

    // Round-robin search starting at rr_ptr; the first candidate found wins.
    always_comb begin
        cand     = port_req & ~mask;
        found    = 1'b0;
        pick     = '0;
        sel_addr = '0;
        sel_din  = '0;
        rr_idx   = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            rr_idx = (32'(rr_ptr) + k) % NUM_PORTS;
            if (!found && cand[PW'(rr_idx)]) begin
                found    = 1'b1;
                pick     = PW'(rr_idx);
                sel_addr = port_addr[7*rr_idx +: 7];
                sel_din  = port_din[16*rr_idx +: 16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        do_update  = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant      = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                do_update  = 1'b1;
                state_next = ACK;
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        upd_mapped = (upd_addr >= ADDR_BASE) && (32'(upd_addr) < ADDR_LIMIT);
        rd_mapped  = (rd_addr >= ADDR_BASE) && (32'(rd_addr) < ADDR_LIMIT);
        upd_idx    = RW'(upd_addr - ADDR_BASE);
        rd_idx     = RW'(rd_addr - ADDR_BASE);
        clr_hit    = rd_en && rd_clr && rd_mapped;
        upd_hit    = do_update && upd_mapped;
        // A same-cycle clear of the target counter makes the report land on zero.
        upd_base   = (clr_hit && (rd_idx == upd_idx)) ? '0 : cnt[upd_idx];
`ifdef PORT_STAT_SAT_EN
        upd_sum    = {1'b0, upd_base} + 33'(upd_din);
        upd_val    = upd_sum[32] ? '1 : upd_sum[31:0];
`else
        upd_val    = upd_base + 32'(upd_din);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g            <= '0;
            upd_addr     <= '0;
            upd_din      <= '0;
            rr_ptr       <= '0;
            mask         <= '0;
            port_ack     <= '0;
            addr_err_cnt <= '0;
        end else begin
            port_ack <= '0;
            if (state == IDLE) mask <= '0;
            if (grant) begin
                g        <= pick;
                upd_addr <= sel_addr;
                upd_din  <= sel_din;
            end
            if (do_update) begin
                port_ack <= NUM_PORTS'(1) << g;
                mask     <= NUM_PORTS'(1) << g;
                rr_ptr   <= (32'(g) == NUM_PORTS - 1) ? '0 : g + 1'b1;
                if (!upd_mapped && (addr_err_cnt != '1))
                    addr_err_cnt <= addr_err_cnt + 1'b1;
            end
        end
    end

    // The update is ordered after the clear so an accumulate on a cleared counter survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            if (clr_hit) cnt[rd_idx]  <= '0;
            if (upd_hit) cnt[upd_idx] <= upd_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mapped ? cnt[rd_idx] : '0;
        end
    end

endmodule
